// File: rtl/serial_adder_pkg.sv
// Shared types and opcodes for the bit-serial add/subtract sequencer.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic logic state_is_busy(input state_t s);
    return (s == RUN) || (s == DONE);
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// Single-bit combinational full adder cell shared by the serial datapath.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_sum,
  output logic o_cout
);

  assign o_sum  = i_a ^ i_b ^ i_c;
  assign o_cout = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: one full adder, LSB-first, WIDTH+1 cycle latency.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             c_out
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             r_state;
  logic [WIDTH-1:0]   r_a_sr;
  logic [WIDTH-1:0]   r_b_sr;
  // Holds the WIDTH-1 most recent result bits; the newest bit comes straight from the adder.
  logic [WIDTH-2:0]   r_res_sr;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_carry;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;

  logic               w_fa_sum;
  logic               w_fa_cout;
  logic [WIDTH-1:0]   w_res_next;

  full_adder u_fa (
    .i_a    (r_a_sr[0]),
    .i_b    (r_b_sr[0]),
    .i_c    (r_carry),
    .o_sum  (w_fa_sum),
    .o_cout (w_fa_cout)
  );

  assign w_res_next = {w_fa_sum, r_res_sr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_res_sr <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            // Subtract is a + ~b + 1: invert B and force the initial carry.
            r_a_sr  <= a_in;
            r_b_sr  <= (op == OP_SUB) ? ~b_in : b_in;
            r_carry <= (op == OP_SUB) ? 1'b1 : c_in;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
          r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
          r_res_sr <= w_res_next[WIDTH-1:1];
          r_carry  <= w_fa_cout;
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_sum   <= w_res_next;
            r_cout  <= w_fa_cout;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ready   = (r_state == IDLE);
  assign busy    = state_is_busy(r_state);
  assign done    = (r_state == DONE);
  assign sum_out = r_sum;
  assign c_out   = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=8.
module tb_serial_adder_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             c_in;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum_out;
  logic             c_out;

  int errors = 0;
  int checks = 0;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .a_in    (a_in),
    .b_in    (b_in),
    .c_in    (c_in),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .sum_out (sum_out),
    .c_out   (c_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic opv, input logic [7:0] es, input logic ec,
                        input string nm);
    int cyc;
    @(negedge clk);
    start = 1'b1; a_in = a; b_in = b; c_in = cin; op = opv;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1 || ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_accept: busy=%b ready=%b, expected busy=1 ready=0", nm, busy, ready);
    end
    @(negedge clk);
    start = 1'b0; a_in = ~a; b_in = ~b; c_in = ~cin; op = ~opv;
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc !== 8) begin
      errors++;
      $display("FAIL %s_latency: done after %0d edges, expected 8", nm, cyc);
    end
    checks++;
    if (sum_out !== es || c_out !== ec) begin
      errors++;
      $display("FAIL %s_result: sum=%h c=%b, expected sum=%h c=%b", nm, sum_out, c_out, es, ec);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_return: done=%b ready=%b busy=%b, expected 0/1/0", nm, done, ready, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; start = 1'b0; op = 1'b0; a_in = '0; b_in = '0; c_in = 1'b0;
    #3 rst_n = 1'b0;
    #2;
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || sum_out !== 8'h00 || c_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ready=%b busy=%b done=%b sum=%h c=%b, expected 1/0/0/00/0",
               ready, busy, done, sum_out, c_out);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, "add");
  endtask

  task automatic test_carry_chain();
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, "carry_ff_01");
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, "carry_ff_ff_cin");
  endtask

  task automatic test_subtract();
    run_op(8'h10, 8'h01, 1'b1, 1'b1, 8'h0F, 1'b1, "sub_10_01");
    run_op(8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, "sub_borrow");
  endtask

  task automatic test_start_held();
    int ndone;
    @(negedge clk);
    start = 1'b1; a_in = 8'h12; b_in = 8'h34; c_in = 1'b0; op = 1'b0;
    @(posedge clk); #1;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a_in = 8'($urandom); b_in = 8'($urandom); op = 1'($urandom); c_in = 1'($urandom);
      @(posedge clk); #1;
      if (done === 1'b1) ndone++;
    end
    checks++;
    if (ndone !== 1 || done !== 1'b1) begin
      errors++;
      $display("FAIL held_done_count: dones=%0d done_now=%b, expected 1 and 1", ndone, done);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (sum_out !== 8'h46 || c_out !== 1'b0) begin
      errors++;
      $display("FAIL held_result: sum=%h c=%b, expected 46/0", sum_out, c_out);
    end
    @(posedge clk); #1;
    checks++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL held_return: ready=%b done=%b, expected 1/0", ready, done);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    int first;
    int second;
    @(negedge clk);
    start = 1'b1; a_in = 8'h01; b_in = 8'h02; c_in = 1'b0; op = 1'b0;
    first = -1; second = -1;
    for (cyc = 1; cyc <= 30; cyc++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        if (first < 0) first = cyc;
        else begin
          second = cyc;
          break;
        end
      end
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (first !== 9) begin
      errors++;
      $display("FAIL b2b_first: first done at edge %0d, expected 9", first);
    end
    checks++;
    if (second - first !== 10) begin
      errors++;
      $display("FAIL b2b_spacing: done spacing %0d, expected 10", second - first);
    end
    checks++;
    if (sum_out !== 8'h03 || c_out !== 1'b0) begin
      errors++;
      $display("FAIL b2b_result: sum=%h c=%b, expected 03/0", sum_out, c_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    int ndone;
    @(negedge clk);
    start = 1'b1; a_in = 8'hAA; b_in = 8'h55; c_in = 1'b0; op = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || sum_out !== 8'h00 || c_out !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state: ready=%b busy=%b done=%b sum=%h c=%b, expected 1/0/0/00/0",
               ready, busy, done, sum_out, c_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) ndone++;
    end
    checks++;
    if (ndone !== 0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_no_done: dones=%0d ready=%b, expected 0 and 1", ndone, ready);
    end
    run_op(8'h33, 8'h44, 1'b1, 1'b0, 8'h78, 1'b0, "after_reset");
  endtask

  task automatic test_hold();
    int bad;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = 1'b0; a_in = 8'($urandom); b_in = 8'($urandom); op = 1'($urandom); c_in = 1'($urandom);
      @(posedge clk); #1;
      checks++;
      if (sum_out !== 8'h78 || c_out !== 1'b0 || done !== 1'b0) begin
        errors++;
        bad++;
        $display("FAIL hold_cycle%0d: sum=%h c=%b done=%b, expected 78/0/0", i, sum_out, c_out, done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_carry_chain();
    test_subtract();
    test_start_held();
    test_back_to_back();
    test_reset_mid_run();
    test_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
